// File: rtl/can_crc_checker_if.sv
// Receive bit-stream and CRC result bundle between the CAN receive FSM and the CRC-15 checker.
// The master drives the frame bits. The slave (the checker) returns the status and the CRC values.
interface can_crc_checker_if #(
    parameter int CRC_W = 15,
    parameter int LEN_W = 16
);
    logic             start;
    logic [LEN_W-1:0] data_len;
    logic             bit_in;
    logic             bit_valid;
    logic             busy;
    logic             done;
    logic             crc_ok;
    logic             crc_err;
    logic             form_err;
    logic [CRC_W-1:0] calc_crc;
    logic [CRC_W-1:0] rx_crc;

    modport master (
        output start, data_len, bit_in, bit_valid,
        input  busy, done, crc_ok, crc_err, form_err, calc_crc, rx_crc
    );

    modport slave (
        input  start, data_len, bit_in, bit_valid,
        output busy, done, crc_ok, crc_err, form_err, calc_crc, rx_crc
    );
endinterface

// File: rtl/can_crc_checker.sv
// Receive-side CAN CRC-15 checker. It accumulates the CRC over SOF..data, captures the received CRC field
// and the delimiter, then reports match, CRC error or form error with a one-cycle done pulse.
module can_crc_checker #(
    parameter int               CRC_W = 15,
    parameter logic [CRC_W-1:0] POLY  = 15'h4599,
    parameter int               LEN_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    can_crc_checker_if.slave  bus
);
    localparam int BC_W = $clog2(CRC_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_CRCF,
        S_DELIM,
        S_REPORT
    } state_t;

    state_t           state_q,    state_d;
    logic [LEN_W-1:0] cnt_q,      cnt_d;
    logic [BC_W-1:0]  bit_cnt_q,  bit_cnt_d;
    logic [CRC_W-1:0] calc_crc_q, calc_crc_d;
    logic [CRC_W-1:0] rx_crc_q,   rx_crc_d;
    logic             form_err_q, form_err_d;
    logic             crc_ok_q,   crc_ok_d;
    logic             crc_err_q,  crc_err_d;
    logic             fb_bit;

    assign fb_bit = bus.bit_in ^ calc_crc_q[CRC_W-1];

    always_comb begin
        // NOTE: every variable gets a default first so that no path leaves it unassigned and infers a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        calc_crc_d = calc_crc_q;
        rx_crc_d   = rx_crc_q;
        form_err_d = form_err_q;
        crc_ok_d   = crc_ok_q;
        crc_err_d  = crc_err_q;

        // start aborts any frame in progress and takes priority over a bit in the same cycle.
        if (bus.start) begin
            calc_crc_d = '0;
            rx_crc_d   = '0;
            form_err_d = 1'b0;
            crc_ok_d   = 1'b0;
            crc_err_d  = 1'b0;
            bit_cnt_d  = '0;
            cnt_d      = bus.data_len;
            state_d    = (bus.data_len == '0) ? S_CRCF : S_DATA;
        end else begin
            unique case (state_q)
                S_IDLE: ;
                S_DATA: begin
                    if (bus.bit_valid) begin
                        calc_crc_d = {calc_crc_q[CRC_W-2:0], 1'b0} ^ (fb_bit ? POLY : '0);
                        cnt_d      = cnt_q - 1'b1;
                        if (cnt_q == LEN_W'(1)) state_d = S_CRCF;
                    end
                end
                S_CRCF: begin
                    if (bus.bit_valid) begin
                        rx_crc_d = {rx_crc_q[CRC_W-2:0], bus.bit_in};
                        if (bit_cnt_q == BC_W'(CRC_W - 1)) begin
                            bit_cnt_d = '0;
                            state_d   = S_DELIM;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
                S_DELIM: begin
                    // Flags are registered here so that they are already valid in the cycle that done is high.
                    if (bus.bit_valid) begin
                        form_err_d = ~bus.bit_in;
                        crc_err_d  = (calc_crc_q != rx_crc_q);
                        crc_ok_d   = (calc_crc_q == rx_crc_q) & bus.bit_in;
                        state_d    = S_REPORT;
                    end
                end
                S_REPORT: state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so that all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            calc_crc_q <= '0;
            rx_crc_q   <= '0;
            form_err_q <= 1'b0;
            crc_ok_q   <= 1'b0;
            crc_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            calc_crc_q <= calc_crc_d;
            rx_crc_q   <= rx_crc_d;
            form_err_q <= form_err_d;
            crc_ok_q   <= crc_ok_d;
            crc_err_q  <= crc_err_d;
        end
    end

    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = (state_q == S_REPORT);
    assign bus.crc_ok   = crc_ok_q;
    assign bus.crc_err  = crc_err_q;
    assign bus.form_err = form_err_q;
    assign bus.calc_crc = calc_crc_q;
    assign bus.rx_crc   = rx_crc_q;
endmodule

// File: tb/tb_can_crc_checker.sv
// Directed bench for can_crc_checker. The expected CRC values are worked out by hand from polynomial 0x4599.
module tb_can_crc_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks_total  = 0;
    int   checks_passed = 0;
    int   done_cnt      = 0;
    int   busy_low_cnt  = 0;
    logic watch_busy    = 1'b0;

    can_crc_checker_if #(.CRC_W(15), .LEN_W(16)) bus ();

    can_crc_checker dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.done === 1'b1) done_cnt++;
        if (watch_busy && bus.busy !== 1'b1) busy_low_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] len, input logic with_bit);
        bus.start     = 1'b1;
        bus.data_len  = len;
        bus.bit_valid = with_bit;
        bus.bit_in    = with_bit;
        tick();
        bus.start     = 1'b0;
        bus.bit_valid = 1'b0;
    endtask

    task automatic send_bit(input logic b, input int gap);
        bus.bit_valid = 1'b0;
        repeat (gap) tick();
        bus.bit_valid = 1'b1;
        bus.bit_in    = b;
        tick();
        bus.bit_valid = 1'b0;
    endtask

    task automatic send_crc(input logic [14:0] v, input int gap);
        for (int i = 14; i >= 0; i--) send_bit(v[i], gap);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else checks_passed++;
        checks_total++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else checks_passed++;
        checks_total++; if ({bus.crc_ok, bus.crc_err, bus.form_err} !== 3'b000)
            $display("FAIL reset_flags: got %b want 000", {bus.crc_ok, bus.crc_err, bus.form_err}); else checks_passed++;
        checks_total++; if (bus.calc_crc !== 15'h0) $display("FAIL reset_calc: got %h want 0000", bus.calc_crc); else checks_passed++;
        checks_total++; if (bus.rx_crc !== 15'h0) $display("FAIL reset_rx: got %h want 0000", bus.rx_crc); else checks_passed++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_bit();
        do_start(16'd1, 1'b0);
        checks_total++; if (bus.busy !== 1'b1) $display("FAIL single_busy_after_start: got %b want 1", bus.busy); else checks_passed++;
        send_bit(1'b1, 0);
        checks_total++; if (bus.calc_crc !== 15'h4599) $display("FAIL single_calc: got %h want 4599", bus.calc_crc); else checks_passed++;
        send_crc(15'h4599, 0);
        checks_total++; if (bus.rx_crc !== 15'h4599) $display("FAIL single_rx: got %h want 4599", bus.rx_crc); else checks_passed++;
        checks_total++; if (bus.done !== 1'b0) $display("FAIL single_done_early: got %b want 0", bus.done); else checks_passed++;
        send_bit(1'b1, 0);
        checks_total++; if (bus.done !== 1'b1) $display("FAIL single_done: got %b want 1", bus.done); else checks_passed++;
        checks_total++; if ({bus.crc_ok, bus.crc_err, bus.form_err} !== 3'b100)
            $display("FAIL single_flags: got %b want 100", {bus.crc_ok, bus.crc_err, bus.form_err}); else checks_passed++;
        checks_total++; if (bus.busy !== 1'b1) $display("FAIL single_busy_report: got %b want 1", bus.busy); else checks_passed++;
        tick();
        checks_total++; if ({bus.done, bus.busy} !== 2'b00) $display("FAIL single_idle: got done,busy=%b want 00", {bus.done, bus.busy}); else checks_passed++;
        checks_total++; if (bus.crc_ok !== 1'b1) $display("FAIL single_ok_held: got %b want 1", bus.crc_ok); else checks_passed++;
    endtask

    task automatic test_two_bits();
        do_start(16'd2, 1'b0);
        send_bit(1'b1, 0); send_bit(1'b0, 0);
        send_crc(15'h4EAB, 0); send_bit(1'b1, 0);
        checks_total++; if (bus.calc_crc !== 15'h4EAB) $display("FAIL two_calc: got %h want 4eab", bus.calc_crc); else checks_passed++;
        checks_total++; if ({bus.done, bus.crc_ok, bus.crc_err, bus.form_err} !== 4'b1100)
            $display("FAIL two_match: got done,ok,err,form=%b want 1100", {bus.done, bus.crc_ok, bus.crc_err, bus.form_err}); else checks_passed++;
        tick();
        do_start(16'd2, 1'b0);
        checks_total++; if (bus.crc_ok !== 1'b0) $display("FAIL two_start_clears_ok: got %b want 0", bus.crc_ok); else checks_passed++;
        send_bit(1'b1, 0); send_bit(1'b0, 0);
        send_crc(15'h4EAA, 0); send_bit(1'b1, 0);
        checks_total++; if ({bus.done, bus.crc_ok, bus.crc_err, bus.form_err} !== 4'b1010)
            $display("FAIL two_mismatch: got done,ok,err,form=%b want 1010", {bus.done, bus.crc_ok, bus.crc_err, bus.form_err}); else checks_passed++;
        checks_total++; if (bus.rx_crc !== 15'h4EAA) $display("FAIL two_rx: got %h want 4eaa", bus.rx_crc); else checks_passed++;
        tick();
        do_start(16'd2, 1'b0);
        checks_total++; if (bus.crc_err !== 1'b0) $display("FAIL two_start_clears_err: got %b want 0", bus.crc_err); else checks_passed++;
        tick();
    endtask

    task automatic test_zero_len();
        do_start(16'd0, 1'b0);
        send_crc(15'h0000, 0);
        checks_total++; if ({bus.done, bus.busy} !== 2'b01) $display("FAIL zero_in_delim: got done,busy=%b want 01", {bus.done, bus.busy}); else checks_passed++;
        send_bit(1'b1, 0);
        checks_total++; if (bus.done !== 1'b1) $display("FAIL zero_done_latency: got %b want 1", bus.done); else checks_passed++;
        checks_total++; if (bus.calc_crc !== 15'h0) $display("FAIL zero_calc: got %h want 0000", bus.calc_crc); else checks_passed++;
        checks_total++; if ({bus.crc_ok, bus.crc_err, bus.form_err} !== 3'b100)
            $display("FAIL zero_flags: got %b want 100", {bus.crc_ok, bus.crc_err, bus.form_err}); else checks_passed++;
        tick();
        do_start(16'd0, 1'b0);
        send_crc(15'h0000, 0);
        send_bit(1'b0, 0);
        checks_total++; if ({bus.done, bus.crc_ok, bus.crc_err, bus.form_err} !== 4'b1001)
            $display("FAIL zero_form_err: got done,ok,err,form=%b want 1001", {bus.done, bus.crc_ok, bus.crc_err, bus.form_err}); else checks_passed++;
        tick();
        checks_total++; if ({bus.done, bus.form_err} !== 2'b01) $display("FAIL zero_form_held: got done,form=%b want 01", {bus.done, bus.form_err}); else checks_passed++;
    endtask

    task automatic test_gapped();
        int d0;
        d0 = done_cnt;
        busy_low_cnt = 0;
        do_start(16'd2, 1'b0);
        watch_busy = 1'b1;
        send_bit(1'b1, 2); send_bit(1'b0, 2);
        checks_total++; if (bus.calc_crc !== 15'h4EAB) $display("FAIL gap_calc: got %h want 4eab", bus.calc_crc); else checks_passed++;
        send_crc(15'h4EAB, 2);
        send_bit(1'b1, 2);
        watch_busy = 1'b0;
        checks_total++; if ({bus.done, bus.crc_ok, bus.crc_err} !== 3'b110)
            $display("FAIL gap_result: got done,ok,err=%b want 110", {bus.done, bus.crc_ok, bus.crc_err}); else checks_passed++;
        checks_total++; if (busy_low_cnt !== 0) $display("FAIL gap_busy_drop: got %0d low cycles want 0", busy_low_cnt); else checks_passed++;
        tick(); tick();
        checks_total++; if (done_cnt - d0 !== 1) $display("FAIL gap_done_cycles: got %0d want 1", done_cnt - d0); else checks_passed++;
    endtask

    task automatic test_abort();
        int d0;
        d0 = done_cnt;
        do_start(16'd8, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(i[0], 0);
        do_start(16'd1, 1'b1);
        checks_total++; if (bus.calc_crc !== 15'h0) $display("FAIL abort_restart_calc: got %h want 0000", bus.calc_crc); else checks_passed++;
        send_bit(1'b1, 0);
        send_crc(15'h4599, 0);
        send_bit(1'b1, 0);
        checks_total++; if ({bus.done, bus.crc_ok} !== 2'b11) $display("FAIL abort_result: got done,ok=%b want 11", {bus.done, bus.crc_ok}); else checks_passed++;
        checks_total++; if (bus.calc_crc !== 15'h4599) $display("FAIL abort_calc: got %h want 4599", bus.calc_crc); else checks_passed++;
        tick(); tick();
        checks_total++; if (done_cnt - d0 !== 1) $display("FAIL abort_done_count: got %0d want 1", done_cnt - d0); else checks_passed++;
    endtask

    task automatic test_reset_mid();
        int d0;
        d0 = done_cnt;
        do_start(16'd1, 1'b0);
        send_bit(1'b1, 0);
        for (int i = 0; i < 7; i++) send_bit(1'b1, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks_total++; if ({bus.busy, bus.done, bus.crc_ok, bus.crc_err, bus.form_err} !== 5'b0)
            $display("FAIL rstmid_ctrl: got %b want 00000", {bus.busy, bus.done, bus.crc_ok, bus.crc_err, bus.form_err}); else checks_passed++;
        checks_total++; if ({bus.calc_crc, bus.rx_crc} !== 30'h0)
            $display("FAIL rstmid_crc: got calc=%h rx=%h want 0000", bus.calc_crc, bus.rx_crc); else checks_passed++;
        for (int i = 0; i < 10; i++) send_bit(1'b1, 0);
        checks_total++; if ({bus.busy, bus.rx_crc} !== 16'h0) $display("FAIL rstmid_idle_ignores: got busy=%b rx=%h want 0", bus.busy, bus.rx_crc); else checks_passed++;
        checks_total++; if (done_cnt !== d0) $display("FAIL rstmid_no_done: got %0d want %0d", done_cnt, d0); else checks_passed++;
        do_start(16'd2, 1'b0);
        send_bit(1'b1, 0); send_bit(1'b0, 0);
        send_crc(15'h4EAB, 0); send_bit(1'b1, 0);
        checks_total++; if ({bus.done, bus.crc_ok, bus.calc_crc} !== {2'b11, 15'h4EAB})
            $display("FAIL rstmid_next_frame: got done,ok=%b calc=%h want 11 4eab", {bus.done, bus.crc_ok}, bus.calc_crc); else checks_passed++;
        tick();
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.data_len  = '0;
        bus.bit_in    = 1'b0;
        bus.bit_valid = 1'b0;
        test_reset();
        test_single_bit();
        test_two_bits();
        test_zero_len();
        test_gapped();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
